// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master: command encodings, FSM states, frame payload.
package spi_pkg;

    localparam int unsigned FRAME_BITS = 10;
    localparam int unsigned RD_BITS    = 8;
    localparam int unsigned CNT_W      = 4;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SHIFT,
        ST_HOLD,
        ST_RD_WAIT_S,
        ST_RECV,
        ST_GAP
    } spi_state_e;

    typedef struct packed {
        logic [1:0]         cmd;
        logic [RD_BITS-1:0] payload;
    } spi_frame_t;

endpackage

// File: rtl/spi_master_if.sv
// Command port and SPI pins of the SPI master, bundled with master/slave views.
interface spi_master_if;
    import spi_pkg::*;

    logic               start;
    spi_frame_t         cmd_word;
    logic               busy;
    logic               done;
    logic [RD_BITS-1:0] rd_data;
    logic               rd_valid;
    logic               seq_err;
    logic               SS_n;
    logic               MOSI;
    logic               MISO;

    modport master (
        input  start, cmd_word, MISO,
        output busy, done, rd_data, rd_valid, seq_err, SS_n, MOSI
    );

    modport slave (
        output start, cmd_word, MISO,
        input  busy, done, rd_data, rd_valid, seq_err, SS_n, MOSI
    );

endinterface

// File: rtl/spi_mst_shreg.sv
// Load/shift register shared by the TX frame and the RX byte: MSB out, serial in at the LSB.
module spi_mst_shreg
    import spi_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [FRAME_BITS-1:0] load_val,
    input  logic                  shift,
    input  logic                  sin,
    output logic                  msb,
    output logic [RD_BITS-1:0]    shift_lo_c
);

    logic [FRAME_BITS-1:0] sh_q;
    logic [FRAME_BITS-1:0] sh_d;

    always_comb begin
        sh_d = sh_q;
        if (load) begin
            sh_d = load_val;
        end else if (shift) begin
            sh_d = {sh_q[FRAME_BITS-2:0], sin};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign msb = sh_q[FRAME_BITS-1];
    // Low byte as it will look after the current shift; lets the final RX bit land in rd_data directly.
    assign shift_lo_c = {sh_q[RD_BITS-2:0], sin};

endmodule

// File: rtl/spi_master.sv
// SPI master issuing one 10-bit frame per request on the slave's own clock (no SCLK).
// Optional RD_ADDR-before-RD_DATA ordering check: define SPI_MST_SEQ_CHK_EN.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned RD_WAIT  = 2,
    parameter int unsigned IDLE_GAP = 1
) (
    input  logic         clk,
    input  logic         rst,
    spi_master_if.master bus
);

    spi_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         cmd_q, cmd_d;
    logic               ss_n_q, ss_n_d;
    logic               mosi_q, mosi_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rd_valid_q, rd_valid_d;
    logic               seq_err_q, seq_err_d;
    logic [RD_BITS-1:0] rd_data_q, rd_data_d;

    logic               sh_load_c;
    logic               sh_shift_c;
    logic               sh_sin_c;
    logic               sh_msb;
    logic [RD_BITS-1:0] sh_lo_c;
    logic               reject_c;

    spi_mst_shreg u_shreg (
        .clk        (clk),
        .rst        (rst),
        .load       (sh_load_c),
        .load_val   (bus.cmd_word),
        .shift      (sh_shift_c),
        .sin        (sh_sin_c),
        .msb        (sh_msb),
        .shift_lo_c (sh_lo_c)
    );

    // Next state, counter and registered-output values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cmd_d      = cmd_q;
        rd_data_d  = rd_data_q;
        mosi_d     = 1'b0;
        seq_err_d  = 1'b0;
        sh_load_c  = 1'b0;
        sh_shift_c = 1'b0;
        sh_sin_c   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (reject_c) begin
                        seq_err_d = 1'b1;
                    end else begin
                        state_d   = ST_LEAD;
                        cmd_d     = bus.cmd_word.cmd;
                        sh_load_c = 1'b1;
                    end
                end
            end
            ST_LEAD: begin
                state_d = ST_SHIFT;
                cnt_d   = CNT_W'(FRAME_BITS);
                mosi_d  = sh_msb;
            end
            // The first SHIFT cycle repeats bit 9 as the direction bit, so shifting lags MOSI by one cycle.
            ST_SHIFT: begin
                if (cnt_q != '0) begin
                    mosi_d     = sh_msb;
                    sh_shift_c = 1'b1;
                    cnt_d      = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cmd_q == CMD_RD_DATA) begin
                    state_d = ST_RD_WAIT_S;
                    cnt_d   = CNT_W'(RD_WAIT - 1);
                end else begin
                    state_d = ST_GAP;
                    cnt_d   = CNT_W'(IDLE_GAP - 1);
                end
            end
            ST_RD_WAIT_S: begin
                if (cnt_q == '0) begin
                    state_d = ST_RECV;
                    cnt_d   = CNT_W'(RD_BITS - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RECV: begin
                sh_shift_c = 1'b1;
                sh_sin_c   = bus.MISO;
                if (cnt_q == '0) begin
                    state_d   = ST_GAP;
                    cnt_d     = CNT_W'(IDLE_GAP - 1);
                    rd_data_d = sh_lo_c;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ss_n_d     = (state_d == ST_IDLE) || (state_d == ST_GAP);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_GAP) && (state_q != ST_GAP);
        rd_valid_d = done_d && (cmd_q == CMD_RD_DATA);
    end

`ifdef SPI_MST_SEQ_CHK_EN
    logic addr_armed_q, addr_armed_d;

    // Armed by a completed RD_ADDR, consumed by a completed RD_DATA.
    always_comb begin
        addr_armed_d = addr_armed_q;
        if (done_d && (cmd_q == CMD_RD_ADDR)) begin
            addr_armed_d = 1'b1;
        end else if (done_d && (cmd_q == CMD_RD_DATA)) begin
            addr_armed_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_armed_q <= 1'b0;
        end else begin
            addr_armed_q <= addr_armed_d;
        end
    end

    assign reject_c = (bus.cmd_word.cmd == CMD_RD_DATA) && !addr_armed_q;
`else
    assign reject_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cmd_q      <= CMD_WR_ADDR;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            seq_err_q  <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            ss_n_q     <= ss_n_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
            seq_err_q  <= seq_err_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign bus.SS_n     = ss_n_q;
    assign bus.MOSI     = mosi_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.seq_err  = seq_err_q;
    assign bus.rd_data  = rd_data_q;

endmodule
